// File: rtl/axi_read_responder.sv
// AXI4 read-only slave (AR/R) over a side-loaded 64-bit word memory: FIXED, INCR and WRAP bursts with SLVERR.
// Optional build macro AXI_RD_STALL_EN: rvalid drops for one cycle after every accepted beat.
module axi_read_responder #(
  parameter int unsigned ID_WIDTH   = 13,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ID_WIDTH-1:0]          s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic [7:0]                   s_axi_arlen,
  input  logic [2:0]                   s_axi_arsize,
  input  logic [1:0]                   s_axi_arburst,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [ID_WIDTH-1:0]          s_axi_rid,
  output logic [DATA_WIDTH-1:0]        s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rlast,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic                         mem_we,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_waddr,
  input  logic [DATA_WIDTH-1:0]        mem_wdata,
  output logic [2:0]                   dbg_state
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1.
  // Once rvalid is high, rid/rdata/rresp/rlast stay frozen until the rready handshake.
  // ADDR latches the request, LOAD reads the first word, GAP is the optional post-beat bubble.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_LOAD = 3'd2,
    S_BEAT = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t state, state_next;

  logic                  ar_fire;
  logic                  r_fire;
  logic                  load_beat;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [1:0]            burst_q;
  logic                  burst_err_q;
  logic [7:0]            beat_cnt;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;
  logic                  rlast_q;

  logic                  wrap_len_ok;
  logic                  bad_req;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [ADDR_WIDTH-1:0] load_addr;
  logic [ADDR_WIDTH-1:0] load_off;
  logic                  load_under;
  logic [ADDR_WIDTH-1:0] load_word;
  logic                  load_oor;
  logic [IDX_W-1:0]      load_idx;
  logic [7:0]            load_cnt;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next    = state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    ar_fire       = 1'b0;
    r_fire        = 1'b0;
    load_beat     = 1'b0;
    case (state)
      S_IDLE: begin
        s_axi_arready = !reset;
        ar_fire       = s_axi_arvalid && !reset;
        if (ar_fire) begin
          state_next = S_ADDR;
        end
      end
      S_ADDR: begin
        state_next = S_LOAD;
      end
      S_LOAD: begin
        load_beat  = 1'b1;
        state_next = S_BEAT;
      end
      S_BEAT: begin
        s_axi_rvalid = 1'b1;
        r_fire       = s_axi_rready;
        if (r_fire) begin
          if (rlast_q) begin
            state_next = S_IDLE;
          end else begin
`ifdef AXI_RD_STALL_EN
            state_next = S_GAP;
`else
            load_beat  = 1'b1;
`endif
          end
        end
      end
      S_GAP: begin
        load_beat  = 1'b1;
        state_next = S_BEAT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Whole-burst error classification, evaluated on the raw AR fields at handshake time.
  always_comb begin
    wrap_len_ok = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                  (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);
    bad_req     = (s_axi_arsize != 3'd3) || (s_axi_arburst == 2'd3) ||
                  ((s_axi_arburst == 2'd2) && !wrap_len_ok);
  end

  // Address of the beat after the current one; addr[2:0] rides along but never selects a word.
  always_comb begin
    wrap_mask = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << 3) - ADDR_WIDTH'(1);
    incr_addr = addr_q + ADDR_WIDTH'(8);
    case (burst_q)
      2'd1:    next_addr = incr_addr;
      2'd2:    next_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr_q;
    endcase
  end

  // In the back-to-back path the next beat loads on the same edge as the handshake,
  // so it uses next_addr; LOAD and GAP load from the already-updated addr_q.
  always_comb begin
    load_addr               = (state == S_BEAT) ? next_addr : addr_q;
    {load_under, load_off}  = {1'b0, load_addr} - {1'b0, BASE_ADDR};
    load_word               = load_off >> 3;
    load_oor                = load_under || (load_word >= ADDR_WIDTH'(MEM_WORDS));
    load_idx                = load_word[IDX_W-1:0];
    load_cnt                = (state == S_LOAD) ? 8'd0 : beat_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      burst_err_q <= 1'b0;
      beat_cnt    <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rlast_q     <= 1'b0;
    end else begin
      if (ar_fire) begin
        id_q        <= s_axi_arid;
        addr_q      <= s_axi_araddr;
        len_q       <= s_axi_arlen;
        burst_q     <= s_axi_arburst;
        burst_err_q <= bad_req;
      end
      if (r_fire) begin
        addr_q <= next_addr;
      end
      if (load_beat) begin
        beat_cnt <= load_cnt;
        rlast_q  <= (load_cnt == len_q);
        if (burst_err_q || load_oor) begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end else begin
          // Old array contents: a preload write on this same edge lands after the read.
          rdata_q <= mem[load_idx];
          rresp_q <= RESP_OKAY;
        end
      end
    end
  end

  // Preload port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign s_axi_rid   = id_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;
  assign s_axi_rlast = rlast_q;
  assign dbg_state   = state;

endmodule
